// File: rtl/dma_arbiter.sv
// dma_arbiter: four-requester DMA bus arbiter (NPR/NPG handshake, idle timeout, OR-safe muxed bus)
module dma_arbiter #(
  parameter int ROUNDROBIN = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  req_i,
  input  logic [3:0]  stb_i,
  input  logic [3:0]  we_i,
  input  logic [17:0] adr0_i,
  input  logic [17:0] adr1_i,
  input  logic [17:0] adr2_i,
  input  logic [17:0] adr3_i,
  input  logic [15:0] dat0_i,
  input  logic [15:0] dat1_i,
  input  logic [15:0] dat2_i,
  input  logic [15:0] dat3_i,
  output logic [3:0]  gnt_o,
  output logic [3:0]  ack_o,
  output logic [3:0]  err_o,
  output logic        dma_req,
  input  logic        dma_ack,
  output logic [17:0] dma_adr18,
  output logic        dma_stb,
  output logic        dma_we,
  output logic [15:0] dma_dat,
  input  logic        global_ack
);
  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;
  state_t          state_q;
  logic [1:0]      owner_q, last_q, win, k;
  logic [9:0]      idle_q, idle_d;
  logic [3:0]      gnt_q, err_q;
  logic            dma_req_q, act, tmo;
  logic [3:0][17:0] adr;
  logic [3:0][15:0] dat;
  assign adr = {adr3_i, adr2_i, adr1_i, adr0_i};
  assign dat = {dat3_i, dat2_i, dat1_i, dat0_i};
  assign act = state_q == GRANT;
  // Scan the search order backwards so the earliest matching candidate is assigned last
  always_comb begin
    win = 2'd0;
    k   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      k = (ROUNDROBIN != 0) ? last_q + 2'd1 + 2'(i) : 2'(i);
      if (req_i[k]) win = k;
    end
  end
  assign idle_d = stb_i[owner_q] ? '0 : (&idle_q ? idle_q : idle_q + 10'd1);
  assign tmo = dma_ack && req_i[owner_q] && idle_d == 10'(TIMEOUT);
  assign gnt_o = gnt_q;
  assign err_o = err_q;
  assign dma_req = dma_req_q;
  assign dma_stb = act & stb_i[owner_q];
  assign dma_we = act & we_i[owner_q];
  assign dma_adr18 = act ? adr[owner_q] : '0;
  assign dma_dat = act ? dat[owner_q] : '0;
  assign ack_o = (act && global_ack && stb_i[owner_q]) ? 4'b0001 << owner_q : '0;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;
      gnt_q     <= '0;
      dma_req_q <= 1'b0;
      err_q     <= '0;
      idle_q    <= '0;
    end else begin
      err_q <= '0;
      case (state_q)
        IDLE: if (|req_i) begin
          owner_q   <= win;
          dma_req_q <= 1'b1;
          state_q   <= REQ;
        end
        REQ: if (!req_i[owner_q]) begin
          dma_req_q <= 1'b0;
          state_q   <= RELEASE;
        end else if (dma_ack) begin
          gnt_q   <= 4'b0001 << owner_q;
          last_q  <= owner_q;
          idle_q  <= '0;
          state_q <= GRANT;
        end
        GRANT: begin
          idle_q <= idle_d;
          if (!dma_ack || (!req_i[owner_q] && !stb_i[owner_q]) || tmo) begin
            gnt_q     <= '0;
            dma_req_q <= 1'b0;
            state_q   <= RELEASE;
            err_q     <= (dma_ack && (req_i[owner_q] || stb_i[owner_q])) ? 4'b0001 << owner_q : '0;
          end
        end
        default: if (!dma_ack) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed scoreboard bench for a fixed-priority and a round-robin arbiter instance
module tb_dma_arbiter;
  logic clk = 1'b0, rst = 1'b1, dma_ack = 1'b0, global_ack = 1'b0;
  logic [3:0] req = '0, stb = '0, we = '0;
  logic [17:0] adr0 = '0, adr1 = '0, adr2 = '0, adr3 = '0;
  logic [15:0] dat0 = '0, dat1 = '0, dat2 = '0, dat3 = '0;
  logic [3:0] g0, a0, e0, g1, a1, e1;
  logic dr0, ds0, dw0, dr1, ds1, dw1;
  logic [17:0] da0, da1;
  logic [15:0] dd0, dd1;
  int total = 0, bad = 0;
  string tq[$];
  logic [31:0] eq[$];
  always #5 clk = ~clk;
  dma_arbiter #(.ROUNDROBIN(0), .TIMEOUT(8)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req), .stb_i(stb), .we_i(we),
    .adr0_i(adr0), .adr1_i(adr1), .adr2_i(adr2), .adr3_i(adr3),
    .dat0_i(dat0), .dat1_i(dat1), .dat2_i(dat2), .dat3_i(dat3),
    .gnt_o(g0), .ack_o(a0), .err_o(e0), .dma_req(dr0), .dma_ack(dma_ack),
    .dma_adr18(da0), .dma_stb(ds0), .dma_we(dw0), .dma_dat(dd0), .global_ack(global_ack));
  dma_arbiter #(.ROUNDROBIN(1), .TIMEOUT(8)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req), .stb_i(stb), .we_i(we),
    .adr0_i(adr0), .adr1_i(adr1), .adr2_i(adr2), .adr3_i(adr3),
    .dat0_i(dat0), .dat1_i(dat1), .dat2_i(dat2), .dat3_i(dat3),
    .gnt_o(g1), .ack_o(a1), .err_o(e1), .dma_req(dr1), .dma_ack(dma_ack),
    .dma_adr18(da1), .dma_stb(ds1), .dma_we(dw1), .dma_dat(dd1), .global_ack(global_ack));
  task automatic want(input string t, input logic [31:0] e);
    tq.push_back(t);
    eq.push_back(e);
  endtask
  task automatic got(input logic [31:0] o);
    string t;
    logic [31:0] e;
    total++;
    if (eq.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty got=%0h", o);
    end else begin
      t = tq.pop_front();
      e = eq.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s got=%0h exp=%0h", t, o, e);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] oh;
    tick(); tick();
    rst = 1'b0;
    want("rst_gnt", 0); got(g0);
    want("rst_req", 0); got(dr0);
    want("rst_err", 0); got(e0);
    want("rst_stb", 0); got(ds0);
    want("rst_adr", 0); got(da0);
    want("rst_gnt_rr", 0); got(g1);
    // fixed priority: lowest set index wins
    req = 4'b0110;
    want("fp_req", 1); want("fp_req_gnt", 0);
    tick(); got(dr0); got(g0);
    dma_ack = 1'b1;
    want("fp_gnt", 4'b0010);
    tick(); got(g0);
    // non-owner strobe/address must be ignored
    stb = 4'b0100; adr1 = 18'h12345; adr2 = 18'o777560; global_ack = 1'b1;
    want("ign_adr", 18'h12345); want("ign_stb", 0); want("ign_ack", 0);
    #1; got(da0); got(ds0); got(a0);
    req = '0; stb = '0; global_ack = 1'b0;
    want("rel_gnt", 0); want("rel_req", 0);
    tick(); got(g0); got(dr0);
    want("rel_hold_gnt", 0); want("rel_hold_req", 0);
    tick(); got(g0); got(dr0);
    dma_ack = 1'b0;
    tick();
    // transfer through owner 2
    req = 4'b0100;
    want("t_req", 1);
    tick(); got(dr0);
    dma_ack = 1'b1;
    want("t_gnt", 4'b0100);
    tick(); got(g0);
    stb = 4'b0100; we = 4'b0100; dat2 = 16'hbeef; dat1 = 16'h1111;
    want("t_adr", 18'o777560); want("t_stb", 1); want("t_we", 1); want("t_dat", 16'hbeef); want("t_ack0", 0);
    #1; got(da0); got(ds0); got(dw0); got(dd0); got(a0);
    global_ack = 1'b1; stb = 4'b0101;
    want("t_ack", 4'b0100);
    #1; got(a0);
    // deferred release: request drops while strobe is still high
    req = '0; global_ack = 1'b0;
    want("def_hold1", 4'b0100); tick(); got(g0);
    want("def_hold2", 4'b0100); tick(); got(g0);
    stb = '0; we = '0;
    want("def_gnt", 0); want("def_req", 0); want("def_stb", 0);
    tick(); got(g0); got(dr0); got(ds0);
    dma_ack = 1'b0;
    tick();
    // back in IDLE: a new request is accepted, then abandoned before grant
    req = 4'b0001;
    want("idle_req", 1); tick(); got(dr0);
    req = '0;
    want("abandon_req", 0); want("abandon_gnt", 0);
    tick(); got(dr0); got(g0);
    tick();
    // timeout with owner 1 idle after grant
    req = 4'b0010;
    tick();
    dma_ack = 1'b1;
    want("tmo_gnt", 4'b0010); tick(); got(g0);
    for (int i = 1; i <= 7; i++) begin
      want("tmo_hold", 4'b0010); want("tmo_noerr", 0);
      tick(); got(g0); got(e0);
    end
    want("tmo_err", 4'b0010); want("tmo_gnt_off", 0);
    tick(); got(e0); got(g0);
    want("tmo_err_pulse", 0); tick(); got(e0);
    req = '0; dma_ack = 1'b0;
    tick();
    // reset in the middle of a grant
    req = 4'b0001;
    tick();
    dma_ack = 1'b1;
    want("r_gnt", 4'b0001); tick(); got(g0);
    stb = 4'b0001; global_ack = 1'b1;
    want("r_ack", 4'b0001); #1; got(a0);
    rst = 1'b1;
    want("r_gnt0", 0); want("r_req0", 0); want("r_ack0", 0); want("r_err0", 0); want("r_stb0", 0);
    tick(); got(g0); got(dr0); got(a0); got(e0); got(ds0);
    rst = 1'b0;
    // CPU reclaims the bus mid-grant
    tick(); tick();
    want("rc_gnt", 4'b0001); #1; got(g0);
    dma_ack = 1'b0;
    want("rc_gnt0", 0); want("rc_err0", 0); want("rc_req0", 0);
    tick(); got(g0); got(e0); got(dr0);
    req = '0; stb = '0; global_ack = 1'b0;
    tick();
    // round-robin order 0,1,2,3,0 with all requests held
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      oh = 4'b0001 << (n % 4);
      tick();
      dma_ack = 1'b1;
      want("rr_gnt", oh); want("fp_all_gnt", 4'b0001);
      tick(); got(g1); got(g0);
      dma_ack = 1'b0;
      tick(); tick();
    end
    req = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
